nor_sequencer: RTL
==================

# nor_sequencer

Micro-sequencer that evaluates a selected two-input logic function on W-bit operands using one shared, external W-bit NOR2 array, one NOR evaluation per clock. Each function is decomposed into NOR steps whose intermediate results are held in internal temporaries. It is the control block for the NOR-only gate library: the NOR array stays purely combinational, and this block owns operand routing, step sequencing and result capture.

## Interface
- W, default 1: operand and result width; all operations are bitwise.
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  request a new operation; sampled only when BUSY=0.
- OP  in  3  function select, latched on accept.
- A  in  W  operand A, latched on accept.
- B  in  W  operand B, latched on accept.
- NOR_A  out  W  first input to the shared NOR2 array.
- NOR_B  out  W  second input to the shared NOR2 array.
- NOR_Z  in  W  output of the shared NOR2 array, equal to ~(NOR_A|NOR_B); combinational, same cycle.
- Z  out  W  result register.
- BUSY  out  1  operation in progress.
- DONE  out  1  one-cycle pulse when Z has been updated.

## Operation
- States: IDLE and EVAL. Step counter S runs 1..N. Temporaries T1..T4 are W bits each. La and Lb are the latched A and B.
- IDLE: NOR_A=NOR_B=0. When START=1, latch OP/A/B, set S=1, BUSY=1, and go to EVAL.
- EVAL: the combinational mux drives NOR_A and NOR_B for step S. At the edge, NOR_Z is written to the temporary named for that step.
- Last step: NOR_Z is written to Z, DONE=1, BUSY=0, S=0, and the state returns to IDLE. Otherwise S increments.
- Step programs, written as (NOR_A, NOR_B) -> destination, with N = step count:
  - 000 NOR, N=1: (La,Lb)->Z.
  - 001 OR, N=2: (La,Lb)->T1; (T1,T1)->Z.
  - 010 AND, N=3: (La,La)->T1; (Lb,Lb)->T2; (T1,T2)->Z.
  - 011 NAND, N=4: the AND program with its last step writing T3 instead of Z; then (T3,T3)->Z.
  - 100 XNOR, N=4: (La,Lb)->T1; (La,T1)->T2; (Lb,T1)->T3; (T2,T3)->Z.
  - 101 XOR, N=5: the XNOR program with its last step writing T4 instead of Z; then (T4,T4)->Z.
  - 110 NOT A, N=1: (La,La)->Z.
  - 111 BUF A, N=2: (La,La)->T1; (T1,T1)->Z.
- Temporaries are not cleared between operations. No step reads a temporary before writing it within the same operation.
- Z holds its value until the next operation completes.
- START while BUSY=1 is ignored; it is not queued.
- Changes on A, B or OP after accept have no effect on the operation in progress.

## Timing
- Reset values: Z=0, BUSY=0, DONE=0, NOR_A=0, NOR_B=0, state IDLE, S=0, T1..T4=0.
- RST=1 mid-operation aborts it with no DONE pulse. Z returns to 0.
- Call the edge that samples START=1 in IDLE "edge k". BUSY goes high after edge k.
- Z is updated and DONE is high after edge k+N. BUSY is low in that same cycle.
- DONE is high for exactly one cycle.
- Latency is N cycles, so an operation occupies N+1 cycles including the accept cycle.
- Back-to-back: START=1 in the DONE cycle is accepted, because the block is in IDLE. DONE then drops and BUSY rises after that edge.
- Throughput is one operation per N+1 cycles.
- NOR_A and NOR_B change only after clock edges; they are glitch-free relative to the step register.

## Test plan
- OR, W=1: accept A=1, B=0, OP=001 at edge k. Required: Z=1 and DONE=1 after edge k+2; BUSY=1 after edges k and k+1 only.
- XOR exhaustive, W=1: all four (A,B) pairs, each issued back-to-back in the previous DONE cycle. Required: Z=0,1,1,0, with DONE every 6 cycles and BUSY low only in the DONE cycles.
- AND, W=4: A=4'b1100, B=4'b1010, OP=010. Required: Z=4'b1000 after edge k+3. NAND on the same operands gives Z=4'b0111 after edge k+4.
- Ignore while busy: XNOR with A=1, B=1, then START=1 with OP=000 during every BUSY cycle. Required: a single DONE after edge k+4 with Z=1, and no second operation afterwards.
- Reset mid-op: XOR started, RST=1 asserted after edge k+2. Required: Z=0, BUSY=0, DONE=0 after the reset edge, with no DONE pulse; a subsequent NOR with A=0, B=0 gives Z=1 after edge k'+1.
- Operand hold: start OR with A=0, B=0, then drive A=1, B=1 during EVAL. Required: Z=0, and the NOR_A/NOR_B trace matches the OR step program on the latched values.

Source files
------------

// File: rtl/nor_sequencer_if.sv
// Operand/result and shared NOR2-array connections of the NOR micro-sequencer.
// The slave modport is the sequencer; the master is the surrounding datapath.
interface nor_sequencer_if #(
    parameter int W = 1
);
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] nor_a;
    logic [W-1:0] nor_b;
    logic [W-1:0] nor_z;
    logic [W-1:0] z;
    logic         busy;
    logic         done;

    modport slave (
        input  start, op, a, b, nor_z,
        output nor_a, nor_b, z, busy, done
    );

    modport master (
        output start, op, a, b, nor_z,
        input  nor_a, nor_b, z, busy, done
    );
endinterface

// File: rtl/nor_sequencer.sv
// Micro-sequencer that evaluates a two-input logic function as a chain of NOR
// steps on one shared external NOR2 array, one step per clock.
module nor_sequencer #(
    parameter int W = 1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    nor_sequencer_if.slave bus
);

    typedef enum logic {
        ST_IDLE,
        ST_EVAL
    } state_e;

    typedef enum logic [2:0] {
        SRC_ZERO,
        SRC_LA,
        SRC_LB,
        SRC_T1,
        SRC_T2,
        SRC_T3,
        SRC_T4
    } src_e;

    // Temporary destinations are encoded so that their low two bits index tmp.
    typedef enum logic [2:0] {
        DST_T1 = 3'd0,
        DST_T2 = 3'd1,
        DST_T3 = 3'd2,
        DST_T4 = 3'd3,
        DST_Z  = 3'd4
    } dst_e;

    typedef struct packed {
        src_e src_a;
        src_e src_b;
        dst_e dst;
    } step_t;

    localparam logic [2:0] OP_NOR  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_XNOR = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_NOTA = 3'b110;
    localparam logic [2:0] OP_BUFA = 3'b111;

    function automatic step_t mk_step(input src_e sa, input src_e sb, input dst_e d);
        step_t s;
        s.src_a = sa;
        s.src_b = sb;
        s.dst   = d;
        return s;
    endfunction

    // Every program's default arm is its final step, so a stray step index
    // still terminates the operation instead of looping.
    function automatic step_t step_lookup(input logic [2:0] op, input logic [2:0] step);
        step_t s;
        s = mk_step(SRC_ZERO, SRC_ZERO, DST_Z);
        case (op)
            OP_NOR: s = mk_step(SRC_LA, SRC_LB, DST_Z);
            OP_OR: begin
                case (step)
                    3'd1:    s = mk_step(SRC_LA, SRC_LB, DST_T1);
                    default: s = mk_step(SRC_T1, SRC_T1, DST_Z);
                endcase
            end
            OP_AND: begin
                case (step)
                    3'd1:    s = mk_step(SRC_LA, SRC_LA, DST_T1);
                    3'd2:    s = mk_step(SRC_LB, SRC_LB, DST_T2);
                    default: s = mk_step(SRC_T1, SRC_T2, DST_Z);
                endcase
            end
            OP_NAND: begin
                case (step)
                    3'd1:    s = mk_step(SRC_LA, SRC_LA, DST_T1);
                    3'd2:    s = mk_step(SRC_LB, SRC_LB, DST_T2);
                    3'd3:    s = mk_step(SRC_T1, SRC_T2, DST_T3);
                    default: s = mk_step(SRC_T3, SRC_T3, DST_Z);
                endcase
            end
            OP_XNOR: begin
                case (step)
                    3'd1:    s = mk_step(SRC_LA, SRC_LB, DST_T1);
                    3'd2:    s = mk_step(SRC_LA, SRC_T1, DST_T2);
                    3'd3:    s = mk_step(SRC_LB, SRC_T1, DST_T3);
                    default: s = mk_step(SRC_T2, SRC_T3, DST_Z);
                endcase
            end
            OP_XOR: begin
                case (step)
                    3'd1:    s = mk_step(SRC_LA, SRC_LB, DST_T1);
                    3'd2:    s = mk_step(SRC_LA, SRC_T1, DST_T2);
                    3'd3:    s = mk_step(SRC_LB, SRC_T1, DST_T3);
                    3'd4:    s = mk_step(SRC_T2, SRC_T3, DST_T4);
                    default: s = mk_step(SRC_T4, SRC_T4, DST_Z);
                endcase
            end
            OP_NOTA: s = mk_step(SRC_LA, SRC_LA, DST_Z);
            OP_BUFA: begin
                case (step)
                    3'd1:    s = mk_step(SRC_LA, SRC_LA, DST_T1);
                    default: s = mk_step(SRC_T1, SRC_T1, DST_Z);
                endcase
            end
            default: s = mk_step(SRC_ZERO, SRC_ZERO, DST_Z);
        endcase
        return s;
    endfunction

    function automatic logic [W-1:0] src_mux(
        input src_e               sel,
        input logic [W-1:0]       la,
        input logic [W-1:0]       lb,
        input logic [3:0][W-1:0]  tmp
    );
        logic [W-1:0] v;
        case (sel)
            SRC_LA:  v = la;
            SRC_LB:  v = lb;
            SRC_T1:  v = tmp[0];
            SRC_T2:  v = tmp[1];
            SRC_T3:  v = tmp[2];
            SRC_T4:  v = tmp[3];
            default: v = '0;
        endcase
        return v;
    endfunction

    state_e              state_q, state_d;
    logic [2:0]          step_q,  step_d;
    logic [2:0]          op_q,    op_d;
    logic [W-1:0]        la_q,    la_d;
    logic [W-1:0]        lb_q,    lb_d;
    logic [3:0][W-1:0]   tmp_q,   tmp_d;
    logic [W-1:0]        z_q,     z_d;
    logic                done_q,  done_d;

    step_t               step_cur;
    logic [W-1:0]        nor_a;
    logic [W-1:0]        nor_b;

    // NOR operands depend only on registered state, so they settle once per edge.
    always_comb begin
        step_cur = step_lookup(op_q, step_q);
        nor_a    = '0;
        nor_b    = '0;
        if (state_q == ST_EVAL) begin
            nor_a = src_mux(step_cur.src_a, la_q, lb_q, tmp_q);
            nor_b = src_mux(step_cur.src_b, la_q, lb_q, tmp_q);
        end
    end

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case leaves one unassigned, which would infer a latch.
        state_d = state_q;
        step_d  = step_q;
        op_d    = op_q;
        la_d    = la_q;
        lb_d    = lb_q;
        tmp_d   = tmp_q;
        z_d     = z_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    la_d    = bus.a;
                    lb_d    = bus.b;
                    step_d  = 3'd1;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (step_cur.dst == DST_Z) begin
                    z_d     = bus.nor_z;
                    done_d  = 1'b1;
                    step_d  = 3'd0;
                    state_d = ST_IDLE;
                end else begin
                    tmp_d[2'(step_cur.dst)] = bus.nor_z;
                    step_d = step_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value regardless of statement order.
        if (rst_i) begin
            state_q <= ST_IDLE;
            step_q  <= 3'd0;
            op_q    <= 3'd0;
            la_q    <= '0;
            lb_q    <= '0;
            // NOTE: the temporaries are a tiny register file, not RAM, and
            // are cleared so a fresh start is fully deterministic.
            tmp_q   <= '0;
            z_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            op_q    <= op_d;
            la_q    <= la_d;
            lb_q    <= lb_d;
            tmp_q   <= tmp_d;
            z_q     <= z_d;
            done_q  <= done_d;
        end
    end

    assign bus.nor_a = nor_a;
    assign bus.nor_b = nor_b;
    assign bus.z     = z_q;
    assign bus.busy  = (state_q == ST_EVAL);
    assign bus.done  = done_q;

endmodule
